// File: rtl/qick_com_pkg.sv
// Shared definitions for the QICK command link: transmitter states, the
// frame sync byte and the operation-to-length decode.
package qick_com_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    CHK  = 2'd3
  } state_t;

  localparam logic [7:0] SYNC_WORD = 8'hA5;

  // The two most significant op bits select 0, 1, 2 or 4 data words;
  // a one-bit op has no length field and always sends none.
  function automatic logic [7:0] len_decode(input logic [7:0] op, input int op_dw);
    logic [7:0] sh;
    logic [1:0] sel;
    if (op_dw < 2) return 8'd0;
    sh  = op >> (op_dw - 2);
    sel = sh[1:0];
    case (sel)
      2'b00:   return 8'd0;
      2'b01:   return 8'd1;
      2'b10:   return 8'd2;
      default: return 8'd4;
    endcase
  endfunction

endpackage

// File: rtl/qick_cmd_tx.sv
// Serialises one captured command per frame onto a valid/ready link:
// header, 0..4 data words, then an XOR check word flagged as last.
module qick_cmd_tx
  import qick_com_pkg::*;
#(
  parameter int OP_DW  = 5,
  parameter int DT_QTY = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_req_i,
  output logic                    cmd_ack_o,
  input  logic [OP_DW-1:0]        cmd_op_i,
  input  logic [DT_QTY-1:0][31:0] cmd_dt_i,
  output logic                    tx_vld_o,
  input  logic                    tx_rdy_i,
  output logic [31:0]             tx_dt_o,
  output logic                    tx_last_o,
  output logic                    busy_o,
  output logic [7:0]              tx_cnt_do
);

  localparam int IW = $clog2(DT_QTY);

  state_t                  state, state_nxt;
  logic                    armed, capture, accept, ack_q;
  logic [7:0]              op_ext, len_dec, op_q, len_q, seq;
  logic [DT_QTY-1:0][31:0] dt_q;
  logic [IW-1:0]           idx;
  logic [31:0]             chk, hdr_word;

  assign op_ext    = 8'(cmd_op_i);
  assign len_dec   = len_decode(op_ext, OP_DW);
  assign hdr_word  = {op_q, seq, len_q, SYNC_WORD};
  assign accept    = tx_vld_o & tx_rdy_i;
  assign cmd_ack_o = ack_q;
  assign busy_o    = (state != IDLE);
  // Completed frames and the sequence number advance together.
  assign tx_cnt_do = seq;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    tx_vld_o  = 1'b0;
    tx_last_o = 1'b0;
    tx_dt_o   = 32'd0;
    case (state)
      IDLE: begin
        if (cmd_req_i && armed) begin
          capture   = 1'b1;
          state_nxt = HDR;
        end
      end
      HDR: begin
        tx_vld_o = 1'b1;
        tx_dt_o  = hdr_word;
        if (tx_rdy_i) state_nxt = (len_q != 8'd0) ? DATA : CHK;
      end
      DATA: begin
        tx_vld_o = 1'b1;
        tx_dt_o  = dt_q[idx];
        if (tx_rdy_i && (idx == IW'(len_q - 8'd1))) state_nxt = CHK;
      end
      CHK: begin
        tx_vld_o  = 1'b1;
        tx_last_o = 1'b1;
        tx_dt_o   = chk;
        if (tx_rdy_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command capture, handshake bookkeeping and the running check word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      armed <= 1'b1;
      ack_q <= 1'b0;
      op_q  <= 8'd0;
      len_q <= 8'd0;
      dt_q  <= '0;
      idx   <= '0;
      chk   <= 32'd0;
      seq   <= 8'd0;
    end else begin
      ack_q <= capture;
      if (!cmd_req_i)   armed <= 1'b1;
      else if (capture) armed <= 1'b0;
      if (capture) begin
        op_q  <= op_ext;
        len_q <= len_dec;
        dt_q  <= cmd_dt_i;
        idx   <= '0;
      end
      if (accept) begin
        case (state)
          HDR:  chk <= tx_dt_o;
          DATA: begin
            chk <= chk ^ tx_dt_o;
            idx <= idx + IW'(1);
          end
          CHK:  seq <= seq + 8'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qick_cmd_tx.sv
// Directed bench for qick_cmd_tx: hand-computed frames, stalls, held
// requests, mid-frame reset and sequence wrap over 256 frames.
module tb_qick_cmd_tx;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             cmd_req_i;
  logic             cmd_ack_o;
  logic [4:0]       cmd_op_i;
  logic [3:0][31:0] cmd_dt_i;
  logic             tx_vld_o;
  logic             tx_rdy_i;
  logic [31:0]      tx_dt_o;
  logic             tx_last_o;
  logic             busy_o;
  logic [7:0]       tx_cnt_do;

  int          vectors = 0;
  int          misses  = 0;
  logic [7:0]  modelSeq = 8'd0;
  logic [31:0] expQ[$];

  qick_cmd_tx #(.OP_DW(5), .DT_QTY(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_req_i(cmd_req_i), .cmd_ack_o(cmd_ack_o),
    .cmd_op_i(cmd_op_i), .cmd_dt_i(cmd_dt_i), .tx_vld_o(tx_vld_o), .tx_rdy_i(tx_rdy_i),
    .tx_dt_o(tx_dt_o), .tx_last_o(tx_last_o), .busy_o(busy_o), .tx_cnt_do(tx_cnt_do)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      misses++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] op, input logic [3:0][31:0] dt);
    cmd_op_i  = op;
    cmd_dt_i  = dt;
    cmd_req_i = 1'b1;
  endtask

  // Runs one frame; expected words come from expQ when preloaded, else from the model.
  task automatic runFrame(input logic [4:0] op, input logic [3:0][31:0] dt,
                          input bit stall, input int reqHold);
    logic [31:0] w[$];
    logic [31:0] hdr, x;
    int          len, k, cyc;
    bit          rdyNow;
    if (expQ.size() != 0) begin
      w = expQ;
      expQ.delete();
    end else begin
      case (op[4:3])
        2'b00:   len = 0;
        2'b01:   len = 1;
        2'b10:   len = 2;
        default: len = 4;
      endcase
      hdr = {3'b000, op, modelSeq, 8'(len), 8'hA5};
      w.push_back(hdr);
      x = hdr;
      for (int i = 0; i < len; i++) begin
        w.push_back(dt[i]);
        x = x ^ dt[i];
      end
      w.push_back(x);
    end
    applyStimulus(op, dt);
    tx_rdy_i = stall ? 1'b0 : 1'b1;
    stepClock();
    checkOutput("ackAfterReq", {31'd0, cmd_ack_o}, 32'd1);
    k   = 0;
    cyc = 0;
    while (k < w.size() && cyc < 64) begin
      if (cyc == reqHold) cmd_req_i = 1'b0;
      cmd_op_i = ~op;
      cmd_dt_i = {4{32'hDEAD_BEEF}};
      rdyNow   = stall ? (cyc % 2 == 1) : 1'b1;
      tx_rdy_i = rdyNow;
      checkOutput("vld", {31'd0, tx_vld_o}, 32'd1);
      checkOutput("word", tx_dt_o, w[k]);
      checkOutput("last", {31'd0, tx_last_o}, {31'd0, (k == w.size() - 1)});
      checkOutput("busy", {31'd0, busy_o}, 32'd1);
      if (cyc > 0) checkOutput("ackPulse", {31'd0, cmd_ack_o}, 32'd0);
      stepClock();
      cyc++;
      if (rdyNow) k++;
    end
    checkOutput("frameDone", k, w.size());
    modelSeq = modelSeq + 8'd1;
    checkOutput("frameCnt", {24'd0, tx_cnt_do}, {24'd0, modelSeq});
    checkOutput("idleVld", {31'd0, tx_vld_o}, 32'd0);
    while (cmd_req_i) begin
      checkOutput("holdBusy", {31'd0, busy_o}, 32'd0);
      checkOutput("holdAck", {31'd0, cmd_ack_o}, 32'd0);
      if (cyc >= reqHold) cmd_req_i = 1'b0;
      stepClock();
      cyc++;
    end
  endtask

  initial begin
    logic [4:0]       op;
    logic [3:0][31:0] dt;
    rst_i     = 1'b1;
    cmd_req_i = 1'b0;
    cmd_op_i  = 5'd0;
    cmd_dt_i  = '0;
    tx_rdy_i  = 1'b1;
    stepClock();
    stepClock();
    checkOutput("rstVld", {31'd0, tx_vld_o}, 32'd0);
    checkOutput("rstBusy", {31'd0, busy_o}, 32'd0);
    checkOutput("rstAck", {31'd0, cmd_ack_o}, 32'd0);
    checkOutput("rstLast", {31'd0, tx_last_o}, 32'd0);
    checkOutput("rstData", tx_dt_o, 32'd0);
    checkOutput("rstCnt", {24'd0, tx_cnt_do}, 32'd0);
    rst_i = 1'b0;
    stepClock();

    dt = {32'd4, 32'd3, 32'd2, 32'd1};
    expQ = '{32'h1900_04A5, 32'd1, 32'd2, 32'd3, 32'd4, 32'h1900_04A1};
    runFrame(5'b11001, dt, 1'b0, 0);

    expQ = '{32'h1901_04A5, 32'd1, 32'd2, 32'd3, 32'd4, 32'h1901_04A1};
    runFrame(5'b11001, dt, 1'b1, 0);

    runFrame(5'b00011, dt, 1'b0, 5);
    runFrame(5'b01010, {32'h0, 32'h0, 32'h0, 32'hCAFE_0001}, 1'b0, 0);

    dt = {32'h4444_0000, 32'h3333_0000, 32'h2222_0000, 32'h1111_0000};
    applyStimulus(5'b11001, dt);
    tx_rdy_i = 1'b1;
    stepClock();
    checkOutput("midHdr", tx_dt_o, {8'h19, modelSeq, 8'h04, 8'hA5});
    cmd_req_i = 1'b0;
    stepClock();
    stepClock();
    checkOutput("midWord2", tx_dt_o, 32'h2222_0000);
    rst_i = 1'b1;
    stepClock();
    checkOutput("midRstVld", {31'd0, tx_vld_o}, 32'd0);
    checkOutput("midRstBusy", {31'd0, busy_o}, 32'd0);
    checkOutput("midRstData", tx_dt_o, 32'd0);
    checkOutput("midRstCnt", {24'd0, tx_cnt_do}, 32'd0);
    rst_i    = 1'b0;
    modelSeq = 8'd0;
    stepClock();
    checkOutput("postRstVld", {31'd0, tx_vld_o}, 32'd0);

    expQ = '{32'h0300_00A5, 32'h0300_00A5};
    runFrame(5'b00011, dt, 1'b0, 0);
    checkOutput("req031Cnt", {24'd0, tx_cnt_do}, 32'd1);

    for (int i = 0; i < 256; i++) begin
      op = {i[1:0], 3'b011};
      dt = {$urandom, $urandom, $urandom, $urandom};
      runFrame(op, dt, 1'b0, 0);
    end
    checkOutput("wrapCnt", {24'd0, tx_cnt_do}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

// File: doc/qick_cmd_tx.md
QICK_CMD_TX -- requirements
Module: qick_cmd_tx

Interface
REQ-001 SHALL have parameter OP_DW, default 5, command operation width, legal range 1..8.
REQ-002 SHALL have parameter DT_QTY, default 4, number of 32-bit command data words, minimum 4.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port cmd_req_i, input, 1 bit: command request from qick_cmd, held high until acknowledged.
REQ-006 SHALL have port cmd_ack_o, output, 1 bit: one-cycle acknowledge pulse to qick_cmd.
REQ-007 SHALL have port cmd_op_i, input, OP_DW bits: command operation.
REQ-008 SHALL have port cmd_dt_i, input, DT_QTY x 32 bits: command data words.
REQ-009 SHALL have port tx_vld_o, input/output direction output, 1 bit: link word valid.
REQ-010 SHALL have port tx_rdy_i, input, 1 bit: link ready.
REQ-011 SHALL have port tx_dt_o, output, 32 bits: link word.
REQ-012 SHALL have port tx_last_o, output, 1 bit: marks the final word of a frame.
REQ-013 SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.
REQ-014 SHALL have port tx_cnt_do, output, 8 bits: count of completed frames, wrapping from 255 to 0.

Function
REQ-015 SHALL implement a state machine with the states IDLE, HDR, DATA and CHK.
REQ-016 SHALL, in IDLE with cmd_req_i=1 and armed=1, capture cmd_op_i and cmd_dt_i, clear armed, drive cmd_ack_o=1 for exactly the next cycle, and enter HDR.
REQ-017 SHALL set armed when cmd_req_i=0 is sampled, so that a request which stays high after its ack is never captured twice.
REQ-018 SHALL derive the data word count len from op[OP_DW-1:OP_DW-2] as 00->0, 01->1, 10->2, 11->4, with data words taken from cmd_dt index 0 upward; when OP_DW=1, len SHALL be 0.
REQ-019 SHALL form the header word as: [31:24] op zero-extended, [23:16] sequence number, [15:8] len, [7:0] 8'hA5.
REQ-020 SHALL reset the sequence number to 0, increment it by 1 after each completed frame, and wrap it from 255 to 0.
REQ-021 SHALL assert tx_vld_o in HDR, DATA and CHK, and hold tx_dt_o and tx_last_o stable while tx_vld_o=1 and tx_rdy_i=0.
REQ-022 SHALL advance one word on each cycle where tx_vld_o=1 and tx_rdy_i=1, with the following transitions:
- HDR to DATA when len>0, otherwise HDR to CHK;
- DATA to CHK after word len-1;
- CHK to IDLE.
REQ-023 SHALL make the check word the 32-bit XOR of the header and all transmitted data words, and assert tx_last_o only on the check word.
REQ-024 SHALL have a latency from request to header of one cycle: with cmd_req_i sampled high at cycle N, cmd_ack_o=1 and a valid header SHALL both be present at cycle N+1.
REQ-025 SHALL increment tx_cnt_do when the check word is accepted, and allow a new capture no earlier than the cycle after CHK is accepted.
REQ-026 SHALL ignore cmd_req_i, cmd_op_i and cmd_dt_i changes outside IDLE; the captured values SHALL be used for the whole frame.
REQ-027 SHALL sustain one word per cycle when tx_rdy_i is held at 1; a frame occupies len+2 link cycles.

Reset
REQ-028 SHALL, on rst_i=1 at any point including mid-frame, clear the following and abandon any partial frame with no further words:
- state to IDLE;
- cmd_ack_o, tx_vld_o, tx_last_o and busy_o to 0;
- tx_dt_o, tx_cnt_do and the sequence number to 0;
- armed to 1.

Structure
REQ-029 SHALL place the state enum, the sync constant 8'hA5 and the len-decode function in the shared qick_com_pkg.
REQ-030 SHALL be a single module with no sub-modules.

Verification
REQ-031 SHALL cover the case op=5'b00011 with tx_rdy_i=1: ack one cycle after req, words 0x0300_00A5 and then 0x0300_00A5 with last, and tx_cnt_do=1.
REQ-032 SHALL cover the case op=5'b11001 with dt={1,2,3,4}: header 0x1900_04A5, then 1, 2, 3, 4, then check 0x1900_04A1.
REQ-033 SHALL cover tx_rdy_i toggling at 50% during the frame of REQ-032: identical words are produced, each held stable while stalled, and busy_o=1 throughout.
REQ-034 SHALL cover cmd_req_i held high for 5 cycles after ack: exactly one frame is produced, and the next frame follows only after req drops and rises again.
REQ-035 SHALL cover 256 back-to-back frames: the sequence field wraps from 0xFF to 0x00 and tx_cnt_do returns to 0.
REQ-036 SHALL cover rst_i=1 during DATA word 2: the next cycle has tx_vld_o=0 and busy_o=0, and the next frame carries sequence 0.
